// File: rtl/pe_program_loader.sv
// Streams 32-bit instruction words into the PE instruction memory, then releases
// the PE for a fixed cycle budget and reports done (or error on an overlong load).
module pe_program_loader #(
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 64,
  parameter int RUN_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              pe_run,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = (RUN_CYCLES > 0) ? CNT_W'(RUN_CYCLES - 1) : '0;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic              s_ready_q, s_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              pe_run_q, pe_run_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic              handshake;

  assign handshake = s_valid & s_ready_q;

  // NOTE: next-state logic uses blocking assignments with every target defaulted
  // first, so no latch can be inferred; the flops below use non-blocking only.
  always_comb begin
    state_d      = state_q;
    s_ready_d    = s_ready_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    pe_run_d     = pe_run_q;
    done_d       = done_q;
    error_d      = error_q;
    word_count_d = word_count_q;
    run_cnt_d    = run_cnt_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d      = LOAD;
          s_ready_d    = 1'b1;
          word_count_d = '0;
          done_d       = 1'b0;
          error_d      = 1'b0;
        end
      end
      LOAD: begin
        if (handshake) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = word_count_q[ADDR_W-1:0];
          imem_wdata_d = s_data;
          word_count_d = word_count_q + 1'b1;
          // s_last wins over overflow on the final-capacity beat
          if (s_last) begin
            state_d   = RUN;
            s_ready_d = 1'b0;
            pe_run_d  = 1'b1;
            run_cnt_d = '0;
          end else if (word_count_q == LAST_IDX) begin
            state_d   = ERR;
            s_ready_d = 1'b0;
            error_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (RUN_CYCLES != 0 && run_cnt_q == RUN_LAST) begin
          state_d  = DONE;
          pe_run_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      s_ready_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      pe_run_q     <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
      run_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      s_ready_q    <= s_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      pe_run_q     <= pe_run_d;
      done_q       <= done_d;
      error_q      <= error_d;
      word_count_q <= word_count_d;
      run_cnt_q    <= run_cnt_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign pe_run     = pe_run_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_pe_program_loader.sv
// Randomized bench for pe_program_loader: a transaction-level model (accepted-word
// queue plus a run countdown) predicts every output each cycle.
module tb_pe_program_loader;

  localparam int ADDR_W     = 6;
  localparam int DEPTH      = 64;
  localparam int RUN_CYCLES = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic              s_valid;
  logic              s_ready;
  logic [31:0]       s_data;
  logic              s_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              pe_run;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  pe_program_loader #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .pe_run(pe_run), .done(done), .error(error), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: words accepted so far, whether a load is open, run cycles left.
  logic [31:0] m_words[$];
  bit          m_loading;
  int          m_run_left;
  bit          m_done, m_error, m_we;
  logic [31:0] m_addr, m_wdata;

  logic [31:0] prog   [DEPTH];
  logic [31:0] tb_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit st, input bit v, input logic [31:0] d, input bit l, input bit r);
    bit was_running;
    if (r) begin
      m_words.delete();
      m_loading = 0; m_run_left = 0; m_done = 0; m_error = 0;
      m_we = 0; m_addr = 0; m_wdata = 0;
      return;
    end
    was_running = (m_run_left > 0);
    m_we = 0;
    if (was_running) begin
      m_run_left--;
      if (m_run_left == 0) m_done = 1;
    end
    if (m_loading && v) begin
      m_we    = 1;
      m_addr  = 32'(m_words.size());
      m_wdata = d;
      m_words.push_back(d);
      if (l) begin
        m_loading  = 0;
        m_run_left = RUN_CYCLES;
      end else if (m_words.size() == DEPTH) begin
        m_loading = 0;
        m_error   = 1;
      end
    end else if (st && !m_loading && !was_running) begin
      m_loading = 1;
      m_words.delete();
      m_done  = 0;
      m_error = 0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit st, input bit v, input logic [31:0] d, input bit l, input bit r);
    rst = r; start = st; s_valid = v; s_data = d; s_last = l;
    model_step(st, v, d, l, r);
    @(posedge clk);
    #1;
    if (imem_we === 1'b1) tb_mem[imem_addr] = imem_wdata;
    check("s_ready",    32'(s_ready),    32'(m_loading));
    check("imem_we",    32'(imem_we),    32'(m_we));
    check("imem_addr",  32'(imem_addr),  m_addr);
    check("imem_wdata", imem_wdata,      m_wdata);
    check("word_count", 32'(word_count), 32'(m_words.size()));
    check("pe_run",     32'(pe_run),     32'(m_run_left > 0));
    check("done",       32'(done),       32'(m_done));
    check("error",      32'(error),      32'(m_error));
  endtask

  // vmode: 0 = valid every cycle, 1 = every other cycle, 2 = random
  task automatic load(input int n, input bit with_last, input int vmode, input bit mid_start);
    int idx = 0;
    int cyc = 0;
    bit v, l, st, hs;
    cycle(1'b1, 1'b0, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    while (m_loading && idx < n && cyc < 2000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      l  = v ? (with_last && idx == n - 1) : 1'($urandom_range(0, 1));
      st = mid_start && (cyc == 3);
      hs = m_loading && v;
      cycle(st, v, prog[idx], l, 1'b0);
      if (hs) idx++;
      cyc++;
    end
    if (cyc >= 2000) check("load_timeout", 32'd1, 32'd0);
  endtask

  // Quiet cycles; start is pulsed occasionally only while the model says the PE runs.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle((m_run_left > 0) && ($urandom_range(0, 3) == 0), 1'b0, $urandom,
            1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic verify_mem();
    for (int i = 0; i < m_words.size(); i++) check("mem", tb_mem[i], prog[i]);
  endtask

  task automatic scrub_mem();
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = 32'hDEAD_BEEF;
  endtask

  task automatic random_prog();
    for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    scrub_mem();
    random_prog();

    // Reset state
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(2);

    // Four-word program, back-to-back beats, then full run to done
    prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_0013;
    load(4, 1'b1, 0, 1'b0);
    idle(20);
    verify_mem();

    // Same program, valid toggling and a start pulse mid-load
    scrub_mem();
    load(4, 1'b1, 1, 1'b1);
    idle(20);
    verify_mem();

    // Capacity overflow: 64 words without s_last, then valid held high in ERR
    random_prog();
    scrub_mem();
    load(DEPTH, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
    verify_mem();

    // 64 words with s_last on the last one, then reset three cycles into RUN
    random_prog();
    scrub_mem();
    load(DEPTH, 1'b1, 2, 1'b0);
    verify_mem();
    idle(2);
    cycle(1'b1, 1'b1, $urandom, 1'b1, 1'b1);
    idle(2);

    // One-word load after reset, run to done
    prog[0] = $urandom;
    load(1, 1'b1, 0, 1'b0);
    idle(20);
    verify_mem();

    // From DONE, a two-word load
    scrub_mem();
    load(2, 1'b1, 2, 1'b0);
    idle(20);
    verify_mem();

    // Random loads of assorted lengths, some overflowing
    for (int k = 0; k < 6; k++) begin
      int  n;
      bit  wl;
      n  = $urandom_range(1, 70);
      wl = 1'($urandom_range(0, 1));
      if (!wl && n < DEPTH) n = DEPTH;
      if (n > DEPTH) n = DEPTH;
      random_prog();
      scrub_mem();
      load(n, wl, 2, 1'($urandom_range(0, 1)));
      idle(20);
      verify_mem();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
